// File: rtl/sync_width_conv_fifo_pkg.sv
// Shared width arithmetic for the width-converting FIFO and its entry RAM.
// An entry is the wide data word with the valid-slice count above it.
package sync_width_conv_fifo_pkg;

  function automatic int width_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int width_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int ratio(input int a, input int b);
    return width_max(a, b) / width_min(a, b);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  function automatic int part_width(input int a, input int b);
    return clog2(ratio(a, b)) + 1;
  endfunction

  function automatic int entry_width(input int a, input int b);
    return width_max(a, b) + part_width(a, b);
  endfunction

  localparam int ENTRY_W = entry_width(16, 128);

endpackage

// File: rtl/width_conv_fifo_ram.sv
// Simple dual-port RAM, one write and one synchronous read port, no reset on storage.
module width_conv_fifo_ram
  import sync_width_conv_fifo_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = ENTRY_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with narrow-to-wide packing or wide-to-narrow unpacking.
// The RAM read port always looks at the post-pop head so a pop can register its data in one edge.
module sync_width_conv_fifo
  import sync_width_conv_fifo_pkg::*;
#(
  parameter int IN_WIDTH         = 16,
  parameter int OUT_WIDTH        = 128,
  parameter int DEPTH_WIDTH      = 5,
  parameter int ALMOST_FULL_NUM  = 28,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [IN_WIDTH-1:0]                       wr_data,
  input  logic                                      wr_flush,
  output logic                                      wr_full,
  output logic                                      almost_full,
  input  logic                                      rd_en,
  output logic [OUT_WIDTH-1:0]                      rd_data,
  output logic [part_width(IN_WIDTH, OUT_WIDTH)-1:0] rd_part,
  output logic                                      rd_empty,
  output logic                                      almost_empty,
  output logic [DEPTH_WIDTH:0]                      water_level
);

  localparam int MAXW  = width_max(IN_WIDTH, OUT_WIDTH);
  localparam int MINW  = width_min(IN_WIDTH, OUT_WIDTH);
  localparam int RATIO = ratio(IN_WIDTH, OUT_WIDTH);
  localparam int PW    = part_width(IN_WIDTH, OUT_WIDTH);
  localparam int EW    = MAXW + PW;
  localparam bit UP    = (IN_WIDTH < OUT_WIDTH);
  localparam bit DOWN  = (IN_WIDTH > OUT_WIDTH);
  localparam logic [PW-1:0]          LAST_SLICE = PW'(RATIO - 1);
  localparam logic [PW-1:0]          FULL_PART  = PW'(RATIO);
  localparam logic [PW-1:0]          ONE_PART   = PW'(1);
  localparam logic [DEPTH_WIDTH:0]   AF_LVL     = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0]   AE_LVL     = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  logic [DEPTH_WIDTH:0] r_wptr, r_rptr, w_rptr_nxt, w_level;
  logic [MAXW-1:0]      r_pack_data, r_unp_data, w_wr_ext, w_pack_fill, w_rd_src;
  logic [PW-1:0]        r_pack_cnt, r_unp_cnt, w_pack_after;
  logic                 r_byp_vld;
  logic [EW-1:0]        r_byp_entry, w_ram_rdata, w_head, w_push_entry;
  logic                 w_ram_full, w_ram_empty, w_wr_acc, w_rd_acc;
  logic                 w_push, w_pop, w_complete, w_flush_go;

  assign w_level      = r_wptr - r_rptr;
  assign w_ram_full   = w_level[DEPTH_WIDTH];
  assign w_ram_empty  = (w_level == '0);
  assign water_level  = w_level;
  assign almost_full  = (w_level >= AF_LVL);
  assign almost_empty = (w_level <= AE_LVL);
  assign wr_full      = UP ? (w_ram_full && (r_pack_cnt == LAST_SLICE)) : w_ram_full;
  assign rd_empty     = DOWN ? (w_ram_empty && (r_unp_cnt == '0)) : w_ram_empty;
  assign w_wr_acc     = wr_en & ~wr_full;
  assign w_rd_acc     = rd_en & ~rd_empty;
  assign w_pop        = w_rd_acc && (!DOWN || (r_unp_cnt == '0));
  assign w_rptr_nxt   = r_rptr + {{DEPTH_WIDTH{1'b0}}, w_pop};
  // A write into the slot being read this edge is not yet visible at the RAM output.
  assign w_head       = r_byp_vld ? r_byp_entry : w_ram_rdata;

  always_comb begin
    w_wr_ext = '0;
    w_wr_ext[IN_WIDTH-1:0] = wr_data;
    w_pack_fill = r_pack_data;
    for (int i = 0; i < RATIO; i++) begin
      if (w_wr_acc && (PW'(i) == r_pack_cnt)) w_pack_fill[i*MINW +: MINW] = wr_data[MINW-1:0];
    end
    w_pack_after = r_pack_cnt + PW'(w_wr_acc);
    w_complete   = UP && w_wr_acc && (r_pack_cnt == LAST_SLICE);
    w_flush_go   = UP && wr_flush && !w_complete && (w_pack_after != '0) && !w_ram_full;
    w_push       = UP ? (w_complete || w_flush_go) : w_wr_acc;
    if (UP) w_push_entry = {(w_complete ? FULL_PART : w_pack_after), w_pack_fill};
    else    w_push_entry = {ONE_PART, w_wr_ext};
    w_rd_src = (DOWN && (r_unp_cnt != '0)) ? r_unp_data : w_head[MAXW-1:0];
  end

  width_conv_fifo_ram #(.AW(DEPTH_WIDTH), .DW(EW)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[DEPTH_WIDTH-1:0]),
    .i_wdata (w_push_entry),
    .i_raddr (w_rptr_nxt[DEPTH_WIDTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_byp_entry <= w_push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_byp_vld   <= 1'b0;
      r_pack_data <= '0;
      r_pack_cnt  <= '0;
      r_unp_data  <= '0;
      r_unp_cnt   <= '0;
      rd_data     <= '0;
      rd_part     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      r_rptr    <= w_rptr_nxt;
      r_byp_vld <= w_push && (r_wptr[DEPTH_WIDTH-1:0] == w_rptr_nxt[DEPTH_WIDTH-1:0]);
      if (UP) begin
        if (w_push) begin
          r_pack_data <= '0;
          r_pack_cnt  <= '0;
        end else if (w_wr_acc) begin
          r_pack_data <= w_pack_fill;
          r_pack_cnt  <= w_pack_after;
        end
      end
      if (DOWN && w_rd_acc) begin
        r_unp_data <= w_rd_src >> MINW;
        r_unp_cnt  <= (r_unp_cnt == '0) ? LAST_SLICE : (r_unp_cnt - ONE_PART);
      end
      if (w_rd_acc) begin
        rd_data <= w_rd_src[OUT_WIDTH-1:0];
        rd_part <= UP ? w_head[EW-1 -: PW] : ONE_PART;
      end
    end
  end

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Bench for sync_width_conv_fifo: upsize x8, downsize /8 and equal-width instances.
// Directed scenarios followed by random traffic against queue-based reference models.
module tb_sync_width_conv_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic         u_wr_en, u_wr_flush, u_rd_en, u_wr_full, u_af, u_rd_empty, u_ae;
  logic [15:0]  u_wr_data;
  logic [127:0] u_rd_data;
  logic [3:0]   u_rd_part;
  logic [4:0]   u_lvl;

  logic         d_wr_en, d_wr_flush, d_rd_en, d_wr_full, d_af, d_rd_empty, d_ae;
  logic [127:0] d_wr_data;
  logic [15:0]  d_rd_data;
  logic [3:0]   d_rd_part;
  logic [5:0]   d_lvl;

  logic         e_wr_en, e_wr_flush, e_rd_en, e_wr_full, e_af, e_rd_empty, e_ae;
  logic [15:0]  e_wr_data, e_rd_data;
  logic [0:0]   e_rd_part;
  logic [4:0]   e_lvl;

  sync_width_conv_fifo #(.IN_WIDTH(16), .OUT_WIDTH(128), .DEPTH_WIDTH(4),
                         .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)) u_up (
    .clk(clk), .rst(rst), .wr_en(u_wr_en), .wr_data(u_wr_data), .wr_flush(u_wr_flush),
    .wr_full(u_wr_full), .almost_full(u_af), .rd_en(u_rd_en), .rd_data(u_rd_data),
    .rd_part(u_rd_part), .rd_empty(u_rd_empty), .almost_empty(u_ae), .water_level(u_lvl));

  sync_width_conv_fifo #(.IN_WIDTH(128), .OUT_WIDTH(16), .DEPTH_WIDTH(5),
                         .ALMOST_FULL_NUM(28), .ALMOST_EMPTY_NUM(2)) u_down (
    .clk(clk), .rst(rst), .wr_en(d_wr_en), .wr_data(d_wr_data), .wr_flush(d_wr_flush),
    .wr_full(d_wr_full), .almost_full(d_af), .rd_en(d_rd_en), .rd_data(d_rd_data),
    .rd_part(d_rd_part), .rd_empty(d_rd_empty), .almost_empty(d_ae), .water_level(d_lvl));

  sync_width_conv_fifo #(.IN_WIDTH(16), .OUT_WIDTH(16), .DEPTH_WIDTH(4),
                         .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)) u_eq (
    .clk(clk), .rst(rst), .wr_en(e_wr_en), .wr_data(e_wr_data), .wr_flush(e_wr_flush),
    .wr_full(e_wr_full), .almost_full(e_af), .rd_en(e_rd_en), .rd_data(e_rd_data),
    .rd_part(e_rd_part), .rd_empty(e_rd_empty), .almost_empty(e_ae), .water_level(e_lvl));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic u_write(input logic [15:0] d);
    u_wr_en = 1'b1;
    u_wr_data = d;
    tick();
    u_wr_en = 1'b0;
  endtask

  task automatic u_read();
    u_rd_en = 1'b1;
    tick();
    u_rd_en = 1'b0;
  endtask

  // Eight consecutive 16-bit values, first value in the lowest slice.
  function automatic logic [127:0] seq_word(input int first);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (128'(16'(first + i)) << (16 * i));
    return r;
  endfunction

  function automatic logic [127:0] pack_q(input logic [15:0] w[$]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w.size(); i++) r = r | (128'(w[i]) << (16 * i));
    return r;
  endfunction

  logic [127:0] uq_data[$];
  int           uq_part[$];
  logic [15:0]  upack[$];
  logic [127:0] dq[$];
  logic [15:0]  dsl[$];
  logic [15:0]  eq[$];
  logic [127:0] u_exp_d, exp_wide;
  int           u_exp_p, e_exp_p;
  logic [15:0]  d_exp_d, e_exp_d;

  task automatic reset_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    {u_wr_en, u_wr_flush, u_rd_en, d_wr_en, d_wr_flush, d_rd_en, e_wr_en, e_wr_flush, e_rd_en} = '0;
    u_wr_data = '0; d_wr_data = '0; e_wr_data = '0;
    #1;
    chk("rst_u_empty", 128'(u_rd_empty), 128'(1));
    chk("rst_u_full", 128'(u_wr_full), 128'(0));
    chk("rst_u_ae", 128'(u_ae), 128'(1));
    chk("rst_u_af", 128'(u_af), 128'(0));
    chk("rst_u_lvl", 128'(u_lvl), 128'(0));
    chk("rst_u_data", u_rd_data, 128'(0));
    chk("rst_u_part", 128'(u_rd_part), 128'(0));
    chk("rst_d_flags", 128'({d_rd_empty, d_wr_full, d_ae, d_af, d_lvl}), 128'({1'b1, 1'b0, 1'b1, 1'b0, 6'd0}));
    chk("rst_e_flags", 128'({e_rd_empty, e_wr_full, e_ae, e_af, e_lvl}), 128'({1'b1, 1'b0, 1'b1, 1'b0, 5'd0}));
    tick();
    rst = 1'b0;
    tick();

    // Upsize: eight words pack into one entry.
    for (int i = 1; i <= 8; i++) u_write(16'(i));
    chk("up_lvl1", 128'(u_lvl), 128'(1));
    chk("up_not_empty", 128'(u_rd_empty), 128'(0));
    u_read();
    chk("up_data", u_rd_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("up_part", 128'(u_rd_part), 128'(8));
    chk("up_empty_after", 128'(u_rd_empty), 128'(1));

    // Flush: empty packer pushes nothing, three held words push a partial entry.
    u_wr_flush = 1'b1; tick(); u_wr_flush = 1'b0;
    chk("flush_noop_lvl", 128'(u_lvl), 128'(0));
    u_write(16'h00A1); u_write(16'h00A2); u_write(16'h00A3);
    chk("flush_held_lvl", 128'(u_lvl), 128'(0));
    u_wr_flush = 1'b1; tick(); u_wr_flush = 1'b0;
    chk("flush_lvl", 128'(u_lvl), 128'(1));
    u_read();
    chk("flush_data", u_rd_data, 128'h0000_00A3_00A2_00A1);
    chk("flush_part", 128'(u_rd_part), 128'(3));
    chk("flush_empty", 128'(u_rd_empty), 128'(1));

    // Full boundary: 16 entries plus 7 packed words.
    for (int i = 1; i <= 134; i++) u_write(16'(i));
    chk("full_before_last", 128'(u_wr_full), 128'(0));
    u_write(16'd135);
    chk("full_rise", 128'(u_wr_full), 128'(1));
    chk("full_lvl", 128'(u_lvl), 128'(16));
    chk("full_af", 128'(u_af), 128'(1));
    u_write(16'hBEEF);
    chk("full_drop_lvl", 128'(u_lvl), 128'(16));
    chk("full_drop_full", 128'(u_wr_full), 128'(1));
    u_read();
    chk("full_pop_data", u_rd_data, seq_word(1));
    chk("full_fall", 128'(u_wr_full), 128'(0));
    u_write(16'h0088);
    chk("full_refill_lvl", 128'(u_lvl), 128'(16));
    for (int k = 1; k < 16; k++) begin
      u_read();
      chk("full_drain", u_rd_data, seq_word(8 * k + 1));
    end
    exp_wide = seq_word(129);
    exp_wide[127:112] = 16'h0088;
    u_read();
    chk("full_last_word", u_rd_data, exp_wide);
    chk("full_drained", 128'(u_rd_empty), 128'(1));

    // Reset mid-stream: 5 entries in RAM and 3 words in the packer.
    for (int i = 0; i < 51; i++) u_write(16'h2000 + 16'(i));
    u_read();
    chk("mid_lvl", 128'(u_lvl), 128'(5));
    rst = 1'b1;
    #1;
    chk("mid_rst_lvl", 128'(u_lvl), 128'(0));
    chk("mid_rst_empty", 128'(u_rd_empty), 128'(1));
    chk("mid_rst_data", u_rd_data, 128'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) u_write(16'h1000 + 16'(i));
    u_read();
    chk("mid_fresh_data", u_rd_data, seq_word(16'h1000));
    chk("mid_fresh_part", 128'(u_rd_part), 128'(8));
    chk("mid_fresh_empty", 128'(u_rd_empty), 128'(1));

    // Downsize: one wide word unpacks into eight reads.
    d_wr_en = 1'b1; d_wr_data = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    tick();
    d_wr_en = 1'b0;
    chk("down_lvl", 128'(d_lvl), 128'(1));
    d_rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("down_slice", 128'(d_rd_data), 128'(i));
      chk("down_part", 128'(d_rd_part), 128'(1));
    end
    chk("down_empty", 128'(d_rd_empty), 128'(1));
    tick();
    d_rd_en = 1'b0;
    chk("down_hold", 128'(d_rd_data), 128'h0008);
    chk("down_still_empty", 128'(d_rd_empty), 128'(1));

    // Equal width: flags around the thresholds.
    for (int i = 0; i < 12; i++) begin
      e_wr_en = 1'b1; e_wr_data = 16'h0100 + 16'(i);
      tick();
    end
    e_wr_en = 1'b0;
    chk("eq_lvl12", 128'(e_lvl), 128'(12));
    chk("eq_af", 128'(e_af), 128'(1));
    e_wr_en = 1'b1; e_rd_en = 1'b1; e_wr_data = 16'h01FF;
    tick();
    e_wr_en = 1'b0;
    chk("eq_pushpop_lvl", 128'(e_lvl), 128'(12));
    chk("eq_pushpop_af", 128'(e_af), 128'(1));
    chk("eq_pushpop_data", 128'(e_rd_data), 128'h0100);
    for (int i = 0; i < 9; i++) tick();
    e_rd_en = 1'b0;
    chk("eq_lvl3", 128'(e_lvl), 128'(3));
    chk("eq_ae_off", 128'(e_ae), 128'(0));
    e_rd_en = 1'b1; tick(); e_rd_en = 1'b0;
    chk("eq_lvl2", 128'(e_lvl), 128'(2));
    chk("eq_ae_on", 128'(e_ae), 128'(1));
    chk("eq_part", 128'(e_rd_part), 128'(1));

    // Random traffic on all three instances against reference models.
    reset_all();
    u_exp_d = '0; u_exp_p = 0; d_exp_d = '0; e_exp_d = '0; e_exp_p = 0;
    for (int c = 0; c < 900; c++) begin
      int ulvl;
      bit mfull, accw, accr;
      u_wr_en    = ($urandom_range(0, 99) < 65);
      u_wr_data  = 16'($urandom);
      u_wr_flush = ($urandom_range(0, 99) < 6);
      u_rd_en    = ($urandom_range(0, 99) < ((c < 450) ? 4 : 25));
      d_wr_en    = ($urandom_range(0, 99) < 8);
      d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
      d_wr_flush = ($urandom_range(0, 99) < 20);
      d_rd_en    = ($urandom_range(0, 99) < 60);
      e_wr_en    = ($urandom_range(0, 99) < ((c < 450) ? 70 : 35));
      e_wr_data  = 16'($urandom);
      e_wr_flush = 1'b0;
      e_rd_en    = ($urandom_range(0, 99) < 50);

      ulvl  = uq_data.size();
      mfull = (ulvl == 16) && (upack.size() == 7);
      chk("rnd_u_full", 128'(u_wr_full), 128'(mfull));
      chk("rnd_u_empty", 128'(u_rd_empty), 128'(ulvl == 0));
      chk("rnd_u_lvl", 128'(u_lvl), 128'(ulvl));
      chk("rnd_u_af", 128'(u_af), 128'(ulvl >= 12));
      chk("rnd_u_ae", 128'(u_ae), 128'(ulvl <= 2));
      accw = u_wr_en && !mfull;
      accr = u_rd_en && (ulvl != 0);
      if (accr) begin
        u_exp_d = uq_data.pop_front();
        u_exp_p = uq_part.pop_front();
      end
      if (accw) upack.push_back(u_wr_data);
      if (upack.size() == 8) begin
        uq_data.push_back(pack_q(upack)); uq_part.push_back(8); upack.delete();
      end else if (u_wr_flush && (upack.size() > 0) && (ulvl < 16)) begin
        uq_data.push_back(pack_q(upack)); uq_part.push_back(upack.size()); upack.delete();
      end

      chk("rnd_d_full", 128'(d_wr_full), 128'(dq.size() == 32));
      chk("rnd_d_empty", 128'(d_rd_empty), 128'((dq.size() == 0) && (dsl.size() == 0)));
      accr = d_rd_en && ((dq.size() != 0) || (dsl.size() != 0));
      accw = d_wr_en && (dq.size() != 32);
      if (accr) begin
        if (dsl.size() == 0) begin
          logic [127:0] e;
          e = dq.pop_front();
          d_exp_d = e[15:0];
          for (int i = 1; i < 8; i++) dsl.push_back(e[16*i +: 16]);
        end else begin
          d_exp_d = dsl.pop_front();
        end
      end
      if (accw) dq.push_back(d_wr_data);

      chk("rnd_e_full", 128'(e_wr_full), 128'(eq.size() == 16));
      chk("rnd_e_empty", 128'(e_rd_empty), 128'(eq.size() == 0));
      chk("rnd_e_lvl", 128'(e_lvl), 128'(eq.size()));
      chk("rnd_e_af", 128'(e_af), 128'(eq.size() >= 12));
      chk("rnd_e_ae", 128'(e_ae), 128'(eq.size() <= 2));
      accr = e_rd_en && (eq.size() != 0);
      accw = e_wr_en && (eq.size() != 16);
      if (accr) begin
        e_exp_d = eq.pop_front();
        e_exp_p = 1;
      end
      if (accw) eq.push_back(e_wr_data);

      tick();
      chk("rnd_u_data", u_rd_data, u_exp_d);
      chk("rnd_u_part", 128'(u_rd_part), 128'(u_exp_p));
      chk("rnd_d_data", 128'(d_rd_data), 128'(d_exp_d));
      chk("rnd_e_data", 128'(e_rd_data), 128'(e_exp_d));
      chk("rnd_e_part", 128'(e_rd_part), 128'(e_exp_p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
